// File: rtl/st7735_pkg.sv
// st7735_pkg: shared opcodes, FSM encoding and panel defaults for the ST7735 window fill.
package st7735_pkg;

    localparam int DEF_WIDTH_PX  = 128;
    localparam int DEF_HEIGHT_PX = 160;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CASET  = 3'd1,
        S_RASET  = 3'd2,
        S_RAMWR  = 3'd3,
        S_PIXEL  = 3'd4,
        S_FINISH = 3'd5
    } state_e;

    // Address-set sequence: opcode, 0x00, start, 0x00, end.
    function automatic logic [7:0] addr_byte(input logic [7:0] cmd, input logic [2:0] idx,
                                             input logic [7:0] lo, input logic [7:0] hi);
        return idx == 3'd0 ? cmd : idx == 3'd2 ? lo : idx == 3'd4 ? hi : 8'h00;
    endfunction

endpackage

// File: rtl/st7735_fill.sv
// st7735_fill: streams CASET/RASET/RAMWR plus a solid RGB565 pixel run
// for a rectangular window as a valid/ready byte stream.
module st7735_fill
    import st7735_pkg::*;
#(
    parameter int WIDTH_PX  = DEF_WIDTH_PX,
    parameter int HEIGHT_PX = DEF_HEIGHT_PX
) (
    input  logic        SYSTEM_CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [7:0]  X0,
    input  logic [7:0]  X1,
    input  logic [7:0]  Y0,
    input  logic [7:0]  Y1,
    input  logic [15:0] COLOR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  TX_DATA,
    output logic        TX_DC,
    output logic        TX_VALID,
    input  logic        TX_READY
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [14:0] pix_q, pix_d;
    logic [14:0] last_q, last_d;
    logic        lo_q, lo_d;
    logic [7:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [15:0] color_q, color_d;
    logic        err_q, err_d;
    logic        win_ok, xfer;
    logic [14:0] area;

    assign TX_VALID = state_q inside {S_CASET, S_RASET, S_RAMWR, S_PIXEL};
    assign BUSY     = TX_VALID;
    assign DONE     = state_q == S_FINISH;
    assign ERR      = err_q;
    assign TX_DC    = TX_VALID && !(state_q != S_PIXEL && idx_q == 3'd0);
    assign TX_DATA  = state_q == S_CASET ? addr_byte(CMD_CASET, idx_q, x0_q, x1_q) :
                      state_q == S_RASET ? addr_byte(CMD_RASET, idx_q, y0_q, y1_q) :
                      state_q == S_RAMWR ? CMD_RAMWR :
                      state_q == S_PIXEL ? (lo_q ? color_q[7:0] : color_q[15:8]) : 8'h00;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        last_d  = last_q;
        lo_d    = lo_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        color_d = color_q;
        err_d   = 1'b0;
        win_ok  = (X0 <= X1) && (32'(X1) < WIDTH_PX) && (Y0 <= Y1) && (32'(Y1) < HEIGHT_PX);
        // Only meaningful for an accepted window, where it is at most 128*160 and cannot wrap.
        area    = ({7'd0, X1 - X0} + 15'd1) * ({7'd0, Y1 - Y0} + 15'd1);
        xfer    = TX_VALID && TX_READY;
        case (state_q)
            S_IDLE: begin
                if (START && win_ok) begin
                    state_d = S_CASET;
                    idx_d   = 3'd0;
                    x0_d    = X0;
                    x1_d    = X1;
                    y0_d    = Y0;
                    y1_d    = Y1;
                    color_d = COLOR;
                    last_d  = area - 15'd1;
                end else if (START) begin
                    err_d = 1'b1;
                end
            end
            S_CASET, S_RASET: begin
                if (xfer) begin
                    idx_d = idx_q == 3'd4 ? 3'd0 : idx_q + 3'd1;
                    if (idx_q == 3'd4) state_d = state_q == S_CASET ? S_RASET : S_RAMWR;
                end
            end
            S_RAMWR: begin
                if (xfer) begin
                    state_d = S_PIXEL;
                    pix_d   = 15'd0;
                    lo_d    = 1'b0;
                end
            end
            S_PIXEL: begin
                if (xfer) begin
                    lo_d = !lo_q;
                    if (lo_q && pix_q == last_q) state_d = S_FINISH;
                    else if (lo_q) pix_d = pix_q + 15'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            pix_q   <= 15'd0;
            last_q  <= 15'd0;
            lo_q    <= 1'b0;
            x0_q    <= 8'd0;
            x1_q    <= 8'd0;
            y0_q    <= 8'd0;
            y1_q    <= 8'd0;
            color_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_st7735_fill.sv
// tb_st7735_fill: scoreboard bench; stimulus queues expected {dc,byte} pairs, a monitor pops them on transfers.
module tb_st7735_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x0 = 8'd0, x1 = 8'd0, y0 = 8'd0, y1 = 8'd0;
    logic [15:0] color = 16'd0;
    logic        busy, done, err, tx_dc, tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, xfer_cnt = 0, done_cnt = 0, stall_cnt = 0;
    int last_xfer_cyc = 0, done_cyc = 0;
    logic busy_at_done = 1'b0;
    logic stall_pend = 1'b0;
    logic [8:0] stall_val = 9'd0;
    logic [8:0] exp_q[$];

    st7735_fill dut (
        .SYSTEM_CLK(clk), .RST_N(rst_n), .START(start),
        .X0(x0), .X1(x1), .Y0(y0), .Y1(y1), .COLOR(color),
        .BUSY(busy), .DONE(done), .ERR(err),
        .TX_DATA(tx_data), .TX_DC(tx_dc), .TX_VALID(tx_valid), .TX_READY(tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: a byte is taken on the next rising edge when valid, ready and out of reset.
    always @(negedge clk) begin
        if (stall_pend) chk("stall_hold", {tx_valid, tx_dc, tx_data}, {1'b1, stall_val});
        stall_pend = rst_n && tx_valid && !tx_ready;
        stall_val  = {tx_dc, tx_data};
        if (stall_pend) stall_cnt++;
        if (rst_n && tx_valid && tx_ready) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_byte", {tx_dc, tx_data}, 9'h1FF);
            else chk("byte", {tx_dc, tx_data}, exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    task automatic push_fill(input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] col);
        int n;
        n = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
        exp_q.push_back({1'b0, 8'h2A}); exp_q.push_back(9'h100); exp_q.push_back({1'b1, a0});
        exp_q.push_back(9'h100); exp_q.push_back({1'b1, a1});
        exp_q.push_back({1'b0, 8'h2B}); exp_q.push_back(9'h100); exp_q.push_back({1'b1, b0});
        exp_q.push_back(9'h100); exp_q.push_back({1'b1, b1});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, col[15:8]});
            exp_q.push_back({1'b1, col[7:0]});
        end
    endtask

    task automatic do_start(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] col);
        @(posedge clk); #1;
        x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = col; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(n < bound), 32'd1);
    endtask

    initial begin
        int base, dbase, ev, eb, ee, busy_low, n;
        logic [8:0] fixed[15];

        // Reset, with START held high throughout: nothing may start.
        start = 1'b1; x1 = 8'd3; y1 = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {busy, done, err, tx_valid, tx_dc, tx_data}, 13'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_start", {busy, tx_valid}, 2'b00);

        // 2x1 red window, unstalled, hand-computed stream.
        fixed = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100,
                  9'h100, 9'h100, 9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
        foreach (fixed[i]) exp_q.push_back(fixed[i]);
        base = xfer_cnt; dbase = done_cnt;
        do_start(8'd0, 8'd1, 8'd0, 8'd0, 16'hF800);
        chk("first_cmd", {tx_valid, tx_dc, tx_data}, {2'b10, 8'h2A});
        wait_done(100);
        repeat (3) @(posedge clk);
        #1;
        chk("small_xfers", 32'(xfer_cnt - base), 32'd15);
        chk("small_done_once", 32'(done_cnt - dbase), 32'd1);
        chk("small_done_timing", 32'(done_cyc), 32'(last_xfer_cyc + 1));
        chk("small_busy_at_done", {31'd0, busy_at_done}, 32'd0);
        chk("small_queue_empty", 32'(exp_q.size()), 32'd0);

        // Full panel window.
        push_fill(8'd0, 8'd127, 8'd0, 8'd159, 16'h5AA5);
        base = xfer_cnt; dbase = done_cnt; busy_low = 0; n = 0;
        do_start(8'd0, 8'd127, 8'd0, 8'd159, 16'h5AA5);
        while (!done && n < 45000) begin
            @(negedge clk);
            #2;
            if (!done && !busy) busy_low++;
            n++;
        end
        chk("full_done_timeout", 32'(n < 45000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("full_xfers", 32'(xfer_cnt - base), 32'd40971);
        chk("full_done_once", 32'(done_cnt - dbase), 32'd1);
        chk("full_busy_gaps", 32'(busy_low), 32'd0);
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3x2 window under random back-pressure.
        push_fill(8'd10, 8'd12, 8'd20, 8'd21, 16'h1357);
        base = xfer_cnt; stall_cnt = 0; n = 0;
        do_start(8'd10, 8'd12, 8'd20, 8'd21, 16'h1357);
        while (!done && n < 500) begin
            tx_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        tx_ready = 1'b1;
        chk("stall_done_timeout", 32'(n < 500), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_xfers", 32'(xfer_cnt - base), 32'd23);
        chk("stall_seen", 32'(stall_cnt > 0), 32'd1);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Rejected windows: inverted columns, then row beyond the panel.
        for (int k = 0; k < 2; k++) begin
            ev = 0; eb = 0; ee = 0;
            if (k == 0) do_start(8'd5, 8'd4, 8'd0, 8'd0, 16'hFFFF);
            else do_start(8'd0, 8'd0, 8'd0, 8'd160, 16'hFFFF);
            chk("err_next_cycle", {31'd0, err}, 32'd1);
            for (int i = 0; i < 9; i++) begin
                ev += int'(tx_valid); eb += int'(busy); ee += int'(err);
                @(posedge clk); #1;
            end
            chk("err_no_valid", 32'(ev), 32'd0);
            chk("err_no_busy", 32'(eb), 32'd0);
            chk("err_single_pulse", 32'(ee), 32'd1);
        end

        // Reset mid-fill after the 6th pixel byte, then a fresh 1x1 fill.
        push_fill(8'd0, 8'd1, 8'd0, 8'd1, 16'h07E0);
        void'(exp_q.pop_back()); void'(exp_q.pop_back());
        base = xfer_cnt; dbase = done_cnt; n = 0;
        do_start(8'd0, 8'd1, 8'd0, 8'd1, 16'h07E0);
        while (xfer_cnt - base < 17 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        chk("rst_mid_reach", 32'(xfer_cnt - base), 32'd17);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_valid", {tx_valid, busy, tx_dc, tx_data}, 11'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_no_resume", {tx_valid, busy}, 2'b00);
        chk("rst_mid_no_done", 32'(done_cnt - dbase), 32'd0);
        chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);
        push_fill(8'd7, 8'd7, 8'd9, 8'd9, 16'hBEEF);
        base = xfer_cnt;
        do_start(8'd7, 8'd7, 8'd9, 8'd9, 16'hBEEF);
        chk("fresh_first_cmd", {tx_valid, tx_dc, tx_data}, {2'b10, 8'h2A});
        wait_done(100);
        repeat (2) @(posedge clk);
        #1;
        chk("one_px_xfers", 32'(xfer_cnt - base), 32'd13);

        // START and input changes mid-fill, plus START in the DONE cycle: all ignored.
        push_fill(8'd0, 8'd1, 8'd0, 8'd0, 16'h1234);
        base = xfer_cnt; dbase = done_cnt;
        do_start(8'd0, 8'd1, 8'd0, 8'd0, 16'h1234);
        repeat (3) @(posedge clk);
        #1;
        color = 16'hFFFF; x1 = 8'd50; start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ev = 0;
        for (int i = 0; i < 6; i++) begin
            ev += int'(tx_valid);
            @(posedge clk); #1;
        end
        chk("mid_xfers", 32'(xfer_cnt - base), 32'd15);
        chk("mid_done_once", 32'(done_cnt - dbase), 32'd1);
        chk("done_cycle_start_ignored", 32'(ev), 32'd0);
        chk("mid_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
